// File: rtl/regfile_core.sv
// 32-entry register file: one synchronous write port, two combinational read ports,
// optional same-cycle write-to-read bypass and a per-register "written since reset" mask.
module regfile_core #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_writeEnable,
    input  logic [4:0]       ctrl_writeReg,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic [4:0]       ctrl_readRegA,
    input  logic [4:0]       ctrl_readRegB,
    output logic [WIDTH-1:0] data_readRegA,
    output logic [WIDTH-1:0] data_readRegB,
    output logic [31:0]      reg_valid
);

    logic [31:0]      onehot;
    logic [WIDTH-1:0] regs [1:31];
    logic [31:1]      written;
    logic [WIDTH-1:0] rd_view [32];
    logic             bypass_a;
    logic             bypass_b;

    always_comb begin
        onehot = 32'd1 << ctrl_writeReg;
    end

    // onehot[0] is deliberately never consumed, so writes to r0 vanish
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
            written <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (ctrl_writeEnable && onehot[i]) begin
                    regs[i]    <= data_writeReg;
                    written[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_view[0] = '0;
        for (int i = 1; i < 32; i++) begin
            rd_view[i] = regs[i];
        end
    end

    // Bypass is suppressed during reset and for r0 so both always read zero
    always_comb begin
        bypass_a = BYPASS && ctrl_reset_n && ctrl_writeEnable &&
                   (ctrl_writeReg == ctrl_readRegA) && (ctrl_readRegA != 5'd0);
        bypass_b = BYPASS && ctrl_reset_n && ctrl_writeEnable &&
                   (ctrl_writeReg == ctrl_readRegB) && (ctrl_readRegB != 5'd0);
        data_readRegA = bypass_a ? data_writeReg : rd_view[ctrl_readRegA];
        data_readRegB = bypass_b ? data_writeReg : rd_view[ctrl_readRegB];
    end

    always_comb begin
        reg_valid = {written, 1'b1};
    end

endmodule

// File: tb/tb_regfile_core.sv
// Self-checking bench for regfile_core: directed scenarios plus random traffic,
// checking a bypassing and a non-bypassing instance against an array model.
module tb_regfile_core;

    logic        clock;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] byp_readA, byp_readB, byp_valid;
    logic [31:0] raw_readA, raw_readB, raw_valid;

    int vectors;
    int miscompares;

    logic [31:0] model [32];
    logic [31:0] model_valid;

    regfile_core #(.WIDTH(32), .BYPASS(1'b1)) dut_byp (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (byp_readA),
        .data_readRegB    (byp_readB),
        .reg_valid        (byp_valid)
    );

    regfile_core #(.WIDTH(32), .BYPASS(1'b0)) dut_raw (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (raw_readA),
        .data_readRegB    (raw_readB),
        .reg_valid        (raw_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] expRead(input logic [4:0] addr, input bit bypass);
        if (addr == 5'd0 || !ctrl_reset_n) return 32'h0;
        if (bypass && ctrl_writeEnable && ctrl_writeReg == addr) return data_writeReg;
        return model[addr];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".bypA"},  byp_readA, expRead(ctrl_readRegA, 1'b1));
        check({tag, ".bypB"},  byp_readB, expRead(ctrl_readRegB, 1'b1));
        check({tag, ".rawA"},  raw_readA, expRead(ctrl_readRegA, 1'b0));
        check({tag, ".rawB"},  raw_readB, expRead(ctrl_readRegB, 1'b0));
        check({tag, ".bypV"},  byp_valid, model_valid);
        check({tag, ".rawV"},  raw_valid, model_valid);
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clock);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wa;
        data_writeReg    = wd;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        #2;
    endtask

    // Commit the model on the rising edge using the inputs held across it
    task automatic clockEdge();
        @(posedge clock);
        if (ctrl_reset_n && ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
            model[ctrl_writeReg]       = data_writeReg;
            model_valid[ctrl_writeReg] = 1'b1;
        end
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model_valid = 32'h1;
    endtask

    task automatic fullSweep();
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'hA500_0000 | 32'(i), 5'(i), 5'((i + 1) % 32));
            checkOutput("sweepWr");
            clockEdge();
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        ctrl_reset_n     = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'h0;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        modelReset();

        // reset state across every address
        repeat (2) @(posedge clock);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            checkOutput("reset");
        end
        check("reset.validConst", byp_valid, 32'h0000_0001);
        @(negedge clock);
        ctrl_reset_n = 1'b1;

        // full write sweep then readback
        fullSweep();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
            checkOutput("sweepRd");
            check("sweepRd.const", raw_readA, (i == 0) ? 32'h0 : (32'hA500_0000 | 32'(i)));
        end
        check("sweep.validConst", raw_valid, 32'hFFFF_FFFF);

        // r0 protection
        applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
        check("r0.pre.byp", byp_readA, 32'h0);
        check("r0.pre.raw", raw_readA, 32'h0);
        clockEdge();
        check("r0.post.byp", byp_readA, 32'h0);
        check("r0.post.raw", raw_readA, 32'h0);
        check("r0.valid", byp_valid, 32'hFFFF_FFFF);

        // bypass behaviour on r5
        applyStimulus(1'b1, 5'd5, 32'h1111_1111, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd5, 32'h2222_2222, 5'd5, 5'd5);
        check("byp.A.on",  byp_readA, 32'h2222_2222);
        check("byp.B.on",  byp_readB, 32'h2222_2222);
        check("byp.A.off", raw_readA, 32'h1111_1111);
        check("byp.B.off", raw_readB, 32'h1111_1111);
        clockEdge();
        check("byp.A.offPost", raw_readA, 32'h2222_2222);
        check("byp.B.offPost", raw_readB, 32'h2222_2222);

        // write-enable gating
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 5'd7, 32'h7777_7777, 5'd7, 5'd7);
            checkOutput("weGate");
            clockEdge();
            checkOutput("weGatePost");
        end
        check("weGate.r7", byp_readA, 32'hA500_0007);

        // random traffic against the model, starting from a fresh reset
        @(negedge clock);
        ctrl_reset_n = 1'b0;
        #1;
        modelReset();
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
                          5'($urandom), 5'($urandom));
            if (k % 16 == 0) ctrl_readRegA = ctrl_writeReg;
            #1;
            checkOutput("rand");
            clockEdge();
            checkOutput("randPost");
        end

        // asynchronous reset between edges with a write to r9 set up
        fullSweep();
        applyStimulus(1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd31);
        ctrl_reset_n = 1'b0;
        #1;
        modelReset();
        check("areset.A", byp_readA, 32'h0);
        check("areset.B", raw_readB, 32'h0);
        check("areset.valid", byp_valid, 32'h0000_0001);
        checkOutput("areset");
        clockEdge();
        checkOutput("aresetHeld");
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        applyStimulus(1'b1, 5'd9, 32'h9, 5'd9, 5'd9);
        clockEdge();
        check("areset.r9", raw_readA, 32'h9);
        check("areset.validR9", raw_valid, 32'h0000_0201);
        checkOutput("aresetPost");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
